// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS memory-stage load path.
//   - Load opcode constants (instr[31:26])
//   - loadState_t : 2-bit load FSM state encoding
//   - loadOp_t    : decoded load type (LW/LH/LHU/LB/LBU)
//   - decodeLoad  : opcode -> {isLoad, op}
//   - isAligned   : natural-alignment test for a load type and addr[1:0]
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } loadState_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } loadOp_t;

    typedef struct packed {
        logic    isLoad;
        loadOp_t op;
    } loadDecode_t;

    function automatic loadDecode_t decodeLoad(input logic [5:0] opcode);
        loadDecode_t d;
        d.isLoad = 1'b1;
        d.op     = LD_LW;
        case (opcode)
            OP_LW:   d.op = LD_LW;
            OP_LH:   d.op = LD_LH;
            OP_LHU:  d.op = LD_LHU;
            OP_LB:   d.op = LD_LB;
            OP_LBU:  d.op = LD_LBU;
            default: d.isLoad = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic isAligned(input loadOp_t op, input logic [1:0] addrLow);
        logic ok;
        case (op)
            LD_LW:          ok = (addrLow == 2'b00);
            LD_LH, LD_LHU:  ok = ~addrLow[0];
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational lane select and sign/zero extension of a
// data-memory read word (little-endian lanes).
// Ports:
//   op      in  loadOp_t  load type
//   addrLow in  2         address bits [1:0] of the load
//   rdata   in  32        word returned by data memory
//   result  out 32        extended load value
module load_extend
    import mips_pkg::*;
(
    input  loadOp_t     op,
    input  logic [1:0]  addrLow,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (addrLow)
            2'b00:   byteSel = rdata[7:0];
            2'b01:   byteSel = rdata[15:8];
            2'b10:   byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = addrLow[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            LD_LB:   result = {{24{byteSel[7]}}, byteSel};
            LD_LBU:  result = {24'h000000, byteSel};
            LD_LH:   result = {{16{halfSel[15]}}, halfSel};
            LD_LHU:  result = {16'h0000, halfSel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: MEM-stage load handler. Issues one read per aligned load,
// stalls the pipeline until the data returns, and registers the extended
// result into WB. Misaligned loads raise adel_w instead of reading.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   instr_m        instruction in MEM (opcode in [31:26])
//   valid_m        MEM holds a live instruction
//   addr_m         effective address
//   flush          kill the instruction in MEM
//   dm_req         read request pulse (combinational)
//   dm_addr        word-aligned read address
//   dm_rdata       read data
//   dm_rvalid      read data valid (one cycle per request)
//   stall_req      hold IF/ID/EX/MEM
//   ld_data_w      extended load result (WB, held until next load)
//   ld_valid_w     ld_data_w valid pulse
//   adel_w         load address error pulse
module dm_load_unit
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_m,
    input  logic          valid_m,
    input  logic [DW-1:0] addr_m,
    input  logic          flush,
    output logic          dm_req,
    output logic [DW-1:0] dm_addr,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_rvalid,
    output logic          stall_req,
    output logic [DW-1:0] ld_data_w,
    output logic          ld_valid_w,
    output logic          adel_w
);

    loadState_t  state;
    loadState_t  stateNext;
    loadDecode_t dec;
    logic        liveLoad;
    logic        aligned;
    logic        takeResult;
    logic        raiseAdel;
    loadOp_t     opQ;
    logic [1:0]  addrLowQ;
    logic [DW-1:0] extData;
    logic        unusedBits;

    assign dec        = decodeLoad(instr_m[31:26]);
    assign liveLoad   = valid_m & ~flush & dec.isLoad;
    assign aligned    = isAligned(dec.op, addr_m[1:0]);
    assign dm_addr    = {addr_m[DW-1:2], 2'b00};
    assign unusedBits = ^instr_m[25:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (liveLoad && aligned) stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (dm_rvalid)  stateNext = ST_IDLE;
                else if (flush) stateNext = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dm_rvalid) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        dm_req     = 1'b0;
        stall_req  = 1'b0;
        takeResult = 1'b0;
        raiseAdel  = 1'b0;
        case (state)
            ST_IDLE: begin
                dm_req    = liveLoad & aligned;
                stall_req = liveLoad & aligned;
                raiseAdel = liveLoad & ~aligned;
            end
            ST_WAIT: begin
                stall_req  = ~dm_rvalid;
                takeResult = dm_rvalid & ~flush;
            end
            ST_DRAIN: begin
                // Hold a waiting load in MEM through the drain response so it
                // is still there to issue once the FSM is back in IDLE.
                stall_req = liveLoad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_valid_w <= 1'b0;
            adel_w     <= 1'b0;
            ld_data_w  <= '0;
            opQ        <= LD_LW;
            addrLowQ   <= '0;
        end else begin
            ld_valid_w <= takeResult;
            adel_w     <= raiseAdel;
            if (takeResult) ld_data_w <= extData;
            if (dm_req) begin
                opQ      <= dec.op;
                addrLowQ <= addr_m[1:0];
            end
        end
    end

    load_extend uExtend (
        .op      (opQ),
        .addrLow (addrLowQ),
        .rdata   (dm_rdata),
        .result  (extData)
    );

endmodule

// File: tb/tb_dm_load_unit.sv
module tb_dm_load_unit;

    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_m;
    logic        valid_m;
    logic [31:0] addr_m;
    logic        flush;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        stall_req;
    logic [31:0] ld_data_w;
    logic        ld_valid_w;
    logic        adel_w;

    dm_load_unit #(.DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_m    (instr_m),
        .valid_m    (valid_m),
        .addr_m     (addr_m),
        .flush      (flush),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_rdata   (dm_rdata),
        .dm_rvalid  (dm_rvalid),
        .stall_req  (stall_req),
        .ld_data_w  (ld_data_w),
        .ld_valid_w (ld_valid_w),
        .adel_w     (adel_w)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stallCount = 0;
    int reqCount = 0;
    bit checking = 1'b0;

    // Outstanding reads seen by the model; killed = flushed, response to be dropped.
    typedef struct {
        logic [5:0] op;
        logic [1:0] lo;
        bit         killed;
    } pend_t;
    pend_t pend[$];

    logic [31:0] expLdData = 32'h0;
    bit          expLdValid = 1'b0;
    bit          expAdel = 1'b0;

    function automatic bit isLoadOp(input logic [5:0] op);
        return (op == T_LW) || (op == T_LB) || (op == T_LH) || (op == T_LBU) || (op == T_LHU);
    endfunction

    function automatic bit isMisaligned(input logic [5:0] op, input logic [1:0] lo);
        if (op == T_LW) return lo != 2'b00;
        if (op == T_LH || op == T_LHU) return lo[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] rdata);
        logic [31:0] w;
        logic [31:0] v;
        w = rdata >> (8 * lo);
        if (op == T_LW) return rdata;
        if (op == T_LB || op == T_LBU) begin
            v = w & 32'hFF;
            if (op == T_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
        end
        v = w & 32'hFFFF;
        if (op == T_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit live;
        bit expReq;
        bit expStall;
        bit nValid;
        bit nAdel;
        logic [31:0] nData;
        if (checking) begin
            check("ld_valid_w", {31'b0, ld_valid_w}, {31'b0, expLdValid});
            check("adel_w", {31'b0, adel_w}, {31'b0, expAdel});
            check("ld_data_w", ld_data_w, expLdData);

            live = valid_m && !flush && isLoadOp(instr_m[31:26]);
            expReq = 1'b0;
            expStall = 1'b0;
            if (pend.size() == 0) begin
                expReq = live && !isMisaligned(instr_m[31:26], addr_m[1:0]);
                expStall = expReq;
            end else if (!pend[0].killed) begin
                expStall = !dm_rvalid;
            end else begin
                expStall = live;
            end
            if (!reset) begin
                check("dm_req", {31'b0, dm_req}, {31'b0, expReq});
                check("stall_req", {31'b0, stall_req}, {31'b0, expStall});
                if (expReq) check("dm_addr", dm_addr, addr_m & 32'hFFFF_FFFC);
            end
            if (stall_req) stallCount++;
            if (dm_req) reqCount++;

            nValid = 1'b0;
            nAdel = 1'b0;
            nData = expLdData;
            if (reset) begin
                pend.delete();
                nData = 32'h0;
            end else if (pend.size() == 0) begin
                if (live) begin
                    if (isMisaligned(instr_m[31:26], addr_m[1:0])) nAdel = 1'b1;
                    else pend.push_back('{instr_m[31:26], addr_m[1:0], 1'b0});
                end
            end else if (dm_rvalid) begin
                if (!pend[0].killed && !flush) begin
                    nValid = 1'b1;
                    nData = modelLoad(pend[0].op, pend[0].lo, dm_rdata);
                end
                void'(pend.pop_front());
            end else if (flush) begin
                pend[0].killed = 1'b1;
            end
            expLdValid = nValid;
            expAdel = nAdel;
            expLdData = nData;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setMem(input logic [5:0] op, input logic [31:0] addr);
        instr_m = {op, 5'd4, 5'd9, 16'h0010};
        addr_m  = addr;
        valid_m = 1'b1;
    endtask

    // Load held in MEM: request cycle, lat-1 wait cycles, then the rvalid cycle.
    task automatic runLoad(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int lat);
        setMem(op, addr);
        dm_rvalid = 1'b0;
        for (int i = 0; i < lat; i++) step();
        dm_rvalid = 1'b1;
        dm_rdata = rdata;
        step();
        dm_rvalid = 1'b0;
        valid_m = 1'b0;
        dm_rdata = 32'h5A5A_A5A5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [5];
        ops[0] = T_LB; ops[1] = T_LBU; ops[2] = T_LH; ops[3] = T_LHU; ops[4] = T_LW;

        reset = 1'b1; flush = 1'b0; valid_m = 1'b0; instr_m = 32'h0;
        addr_m = 32'h0; dm_rdata = 32'h0; dm_rvalid = 1'b0;
        step();
        step();
        check("reset ld_valid_w", {31'b0, ld_valid_w}, 32'd0);
        check("reset adel_w", {31'b0, adel_w}, 32'd0);
        check("reset ld_data_w", ld_data_w, 32'd0);
        check("reset dm_req", {31'b0, dm_req}, 32'd0);
        check("reset stall_req", {31'b0, stall_req}, 32'd0);
        reset = 1'b0;
        checking = 1'b1;
        step();

        // lb at byte 3, one-cycle latency
        stallCount = 0;
        runLoad(T_LB, 32'h0000_1003, 32'h80FF_1234, 1);
        check("lb data", ld_data_w, 32'hFFFF_FF80);
        check("lb valid", {31'b0, ld_valid_w}, 32'd1);
        check("lb stall cycles", stallCount, 32'd1);
        step();
        check("lb valid pulse", {31'b0, ld_valid_w}, 32'd0);

        // lhu / lh at halfword 2, three-cycle latency
        stallCount = 0;
        runLoad(T_LHU, 32'h0000_2002, 32'h8001_0000, 3);
        check("lhu data", ld_data_w, 32'h0000_8001);
        check("lhu stall cycles", stallCount, 32'd3);
        runLoad(T_LH, 32'h0000_2002, 32'h8001_0000, 3);
        check("lh data", ld_data_w, 32'hFFFF_8001);
        step();

        // misaligned lw
        stallCount = 0; reqCount = 0;
        setMem(T_LW, 32'h0000_3002);
        step();
        valid_m = 1'b0;
        check("adel pulse", {31'b0, adel_w}, 32'd1);
        check("adel no ld_valid", {31'b0, ld_valid_w}, 32'd0);
        step();
        check("adel one cycle", {31'b0, adel_w}, 32'd0);
        check("adel no req", reqCount, 32'd0);
        check("adel no stall", stallCount, 32'd0);

        // flush in WAIT, drain, then next load
        reqCount = 0;
        setMem(T_LW, 32'h0000_0300);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        setMem(T_LW, 32'h0000_0400);
        step();
        dm_rvalid = 1'b1; dm_rdata = 32'h1111_1111;
        step();
        dm_rvalid = 1'b0;
        check("drain single req", reqCount, 32'd1);
        check("drain no result", {31'b0, ld_valid_w}, 32'd0);
        step();
        dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        step();
        dm_rvalid = 1'b0; valid_m = 1'b0;
        check("after drain data", ld_data_w, 32'hCAFE_F00D);
        check("after drain valid", {31'b0, ld_valid_w}, 32'd1);
        check("after drain reqs", reqCount, 32'd2);
        step();

        // back-to-back lw / lbu
        reqCount = 0;
        runLoad(T_LW, 32'h0000_0010, 32'hDEAD_BEEF, 1);
        check("b2b lw data", ld_data_w, 32'hDEAD_BEEF);
        runLoad(T_LBU, 32'h0000_0015, 32'h1122_AB44, 1);
        check("b2b lbu data", ld_data_w, 32'h0000_00AB);
        check("b2b reqs", reqCount, 32'd2);
        step();

        // flush with rvalid in WAIT, flush on an idle load, sw, stray rvalid
        setMem(T_LW, 32'h0000_0020);
        step();
        flush = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h7777_7777;
        step();
        dm_rvalid = 1'b0; valid_m = 1'b0; flush = 1'b0;
        check("flush+rvalid no result", {31'b0, ld_valid_w}, 32'd0);
        reqCount = 0;
        setMem(T_LW, 32'h0000_0040); flush = 1'b1;
        step();
        flush = 1'b0;
        setMem(T_SW, 32'h0000_0044);
        step();
        valid_m = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h9999_9999;
        step();
        dm_rvalid = 1'b0;
        check("no req for flush/sw", reqCount, 32'd0);
        step();

        // lane sweep
        for (int o = 0; o < 5; o++) begin
            for (int lo = 0; lo < 4; lo++) begin
                if (isMisaligned(ops[o], 2'(lo))) begin
                    setMem(ops[o], 32'h0000_0800 + 32'(lo));
                    step();
                    valid_m = 1'b0;
                end else begin
                    runLoad(ops[o], 32'h0000_0800 + 32'(lo), 32'h8F7E_C1A5 ^ (32'(o) << 4), 1 + (lo % 2));
                end
                step();
            end
        end

        // reset during WAIT, stale rvalid afterwards
        setMem(T_LW, 32'h0000_0500);
        step();
        reset = 1'b1; valid_m = 1'b0;
        step();
        reset = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1234_5678;
        step();
        dm_rvalid = 1'b0;
        check("rst ld_valid", {31'b0, ld_valid_w}, 32'd0);
        check("rst ld_data", ld_data_w, 32'd0);
        check("rst adel", {31'b0, adel_w}, 32'd0);
        check("rst stall", {31'b0, stall_req}, 32'd0);
        check("rst req", {31'b0, dm_req}, 32'd0);
        step();
        check("rst stale ignored", {31'b0, ld_valid_w}, 32'd0);
        step();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
